// File: rtl/nibble_serial_adder.sv
// Serial wide-operand adder: feeds one 4-bit prefix adder a nibble per clock,
// LSB-first, recirculating the carry, and returns a WIDTH-bit sum plus carry out.

// 4-bit prefix adder: generate/propagate pairs combined in a two-level tree.
module adder (
  input  logic [3:0] a,
  input  logic [3:0] b,
  input  logic       cin,
  output logic [3:0] sum,
  output logic       cout
);

  logic [3:0] g;
  logic [3:0] p;
  logic       g10;
  logic       p10;
  logic       g32;
  logic       p32;
  logic       c1;
  logic       c2;
  logic       c3;

  assign g   = a & b;
  assign p   = a ^ b;

  assign g10 = g[1] | (p[1] & g[0]);
  assign p10 = p[1] & p[0];
  assign g32 = g[3] | (p[3] & g[2]);
  assign p32 = p[3] & p[2];

  assign c1   = g[0] | (p[0] & cin);
  assign c2   = g10  | (p10  & cin);
  assign c3   = g[2] | (p[2] & c2);
  assign cout = g32  | (p32  & c2);

  assign sum  = p ^ {c3, c2, c1, cin};

endmodule

module nibble_serial_adder #(
  parameter int unsigned WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             busy
);

  localparam int unsigned N     = WIDTH / 4;
  localparam int unsigned IDX_W = (N > 1) ? $clog2(N) : 1;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t             state_q;
  state_t             state_d;

  logic [WIDTH-1:0]   a_q;
  logic [WIDTH-1:0]   b_q;
  logic               carry_q;
  logic [IDX_W-1:0]   idx_q;
  logic [WIDTH-1:0]   sum_q;
  logic               cout_q;

  logic [3:0]         a_nib;
  logic [3:0]         b_nib;
  logic [3:0]         add_sum;
  logic               add_cout;
  logic               idx_last;
  logic               accept;
  logic               step;

  assign idx_last = (idx_q == IDX_W'(N - 1));
  assign accept   = (state_q == IDLE) && in_valid;
  assign step     = (state_q == RUN);

  // Select the operand nibbles addressed by the step index.
  always_comb begin
    a_nib = '0;
    b_nib = '0;
    for (int unsigned i = 0; i < N; i++) begin
      if (idx_q == IDX_W'(i)) begin
        a_nib = a_q[4*i +: 4];
        b_nib = b_q[4*i +: 4];
      end
    end
  end

  adder u_adder (
    .a    (a_nib),
    .b    (b_nib),
    .cin  (carry_q),
    .sum  (add_sum),
    .cout (add_cout)
  );

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:    if (in_valid)  state_d = RUN;
      RUN:     if (idx_last)  state_d = DONE;
      DONE:    if (out_ready) state_d = IDLE;
      default:                state_d = IDLE;
    endcase
  end

  // Handshake and status outputs decoded from the state register only.
  always_comb begin
    in_ready  = 1'b0;
    out_valid = 1'b0;
    busy      = 1'b0;
    unique case (state_q)
      IDLE:    in_ready  = 1'b1;
      RUN:     busy      = 1'b1;
      DONE:    out_valid = 1'b1;
      default: in_ready  = 1'b0;
    endcase
  end

  // Operand latch, nibble stepping, carry recirculation and sum collection.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a_q     <= '0;
      b_q     <= '0;
      carry_q <= 1'b0;
      idx_q   <= '0;
      sum_q   <= '0;
      cout_q  <= 1'b0;
    end else if (accept) begin
      a_q     <= a;
      b_q     <= b;
      carry_q <= cin;
      idx_q   <= '0;
      sum_q   <= '0;
    end else if (step) begin
      carry_q <= add_cout;
      for (int unsigned i = 0; i < N; i++) begin
        if (idx_q == IDX_W'(i)) begin
          sum_q[4*i +: 4] <= add_sum;
        end
      end
      if (idx_last) begin
        idx_q  <= '0;
        cout_q <= add_cout;
      end else begin
        idx_q  <= idx_q + IDX_W'(1);
      end
    end
  end

  assign sum  = sum_q;
  assign cout = cout_q;

endmodule

// File: tb/tb_nibble_serial_adder.sv
// Bench for nibble_serial_adder: directed scenarios at WIDTH=16 and WIDTH=4,
// randomized handshake traffic at WIDTH=16 and WIDTH=32 against a queue model.

module tb_nibble_serial_adder;

  logic clk = 1'b0;
  logic rst_n;
  int   n_pass  = 0;
  int   n_total = 0;

  always #5 clk = ~clk;

  // WIDTH=16 instance
  logic        i16_valid, i16_ready, cin16, o16_valid, o16_ready, c16, busy16;
  logic [15:0] a16, b16, s16;
  // WIDTH=32 instance
  logic        i32_valid, i32_ready, cin32, o32_valid, o32_ready, c32, busy32;
  logic [31:0] a32, b32, s32;
  // WIDTH=4 instance
  logic        i4_valid, i4_ready, cin4, o4_valid, o4_ready, c4, busy4;
  logic [3:0]  a4, b4, s4;

  nibble_serial_adder #(.WIDTH(16)) dut16 (
    .clk(clk), .rst_n(rst_n), .in_valid(i16_valid), .in_ready(i16_ready),
    .a(a16), .b(b16), .cin(cin16), .out_valid(o16_valid), .out_ready(o16_ready),
    .sum(s16), .cout(c16), .busy(busy16));

  nibble_serial_adder #(.WIDTH(32)) dut32 (
    .clk(clk), .rst_n(rst_n), .in_valid(i32_valid), .in_ready(i32_ready),
    .a(a32), .b(b32), .cin(cin32), .out_valid(o32_valid), .out_ready(o32_ready),
    .sum(s32), .cout(c32), .busy(busy32));

  nibble_serial_adder #(.WIDTH(4)) dut4 (
    .clk(clk), .rst_n(rst_n), .in_valid(i4_valid), .in_ready(i4_ready),
    .a(a4), .b(b4), .cin(cin4), .out_valid(o4_valid), .out_ready(o4_ready),
    .sum(s4), .cout(c4), .busy(busy4));

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive16(input logic [15:0] a, input logic [15:0] b, input logic ci);
    i16_valid = 1'b1; a16 = a; b16 = b; cin16 = ci;
    tick();
    i16_valid = 1'b0; a16 = '0; b16 = '0; cin16 = 1'b0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    i16_valid = 0; a16 = '0; b16 = '0; cin16 = 0; o16_ready = 0;
    i32_valid = 0; a32 = '0; b32 = '0; cin32 = 0; o32_ready = 0;
    i4_valid  = 0; a4  = '0; b4  = '0; cin4  = 0; o4_ready  = 0;
    #12;
    n_total++;
    if ({i16_ready, o16_valid, busy16, c16, s16} !== {1'b1, 1'b0, 1'b0, 1'b0, 16'h0000})
      $display("FAIL reset16: rdy/vld/busy/cout/sum = %b/%b/%b/%b/%h, want 1/0/0/0/0000",
               i16_ready, o16_valid, busy16, c16, s16);
    else n_pass++;
    n_total++;
    if ({i32_ready, o32_valid, busy32, c32, s32} !== {1'b1, 1'b0, 1'b0, 1'b0, 32'h0})
      $display("FAIL reset32: rdy/vld/busy/cout/sum = %b/%b/%b/%b/%h", i32_ready, o32_valid, busy32, c32, s32);
    else n_pass++;
    @(negedge clk);
    rst_n = 1'b1;
    tick();
  endtask

  task automatic test_carry_ripple();
    int lat;
    o16_ready = 1'b1;
    n_total++;
    if (i16_ready !== 1'b1) $display("FAIL ripple_ready: in_ready=%b want 1", i16_ready);
    else n_pass++;
    drive16(16'hFFFF, 16'h0001, 1'b0);
    lat = 0;
    while (!o16_valid && lat < 20) begin tick(); lat++; end
    n_total++;
    if (lat !== 4) $display("FAIL ripple_latency: got %0d want 4", lat);
    else n_pass++;
    n_total++;
    if ({c16, s16} !== 17'h1_0000) $display("FAIL ripple_result: got %b_%h want 1_0000", c16, s16);
    else n_pass++;
    tick();
    n_total++;
    if ({o16_valid, i16_ready} !== 2'b01)
      $display("FAIL ripple_consume: out_valid/in_ready=%b%b want 01", o16_valid, i16_ready);
    else n_pass++;
  endtask

  task automatic test_busy_ready();
    int lat, busy_cnt, ready_bad;
    o16_ready = 1'b1;
    drive16(16'h1234, 16'h4321, 1'b1);
    lat = 0; busy_cnt = 0; ready_bad = 0;
    while (!o16_valid && lat < 20) begin
      if (busy16) busy_cnt++;
      if (i16_ready) ready_bad++;
      tick(); lat++;
    end
    if (i16_ready) ready_bad++;
    n_total++;
    if (busy_cnt !== 4) $display("FAIL busy_cycles: got %0d want 4", busy_cnt);
    else n_pass++;
    n_total++;
    if (ready_bad !== 0) $display("FAIL ready_low_while_busy: in_ready seen high %0d times want 0", ready_bad);
    else n_pass++;
    n_total++;
    if ({c16, s16} !== 17'h0_5556) $display("FAIL busy_result: got %b_%h want 0_5556", c16, s16);
    else n_pass++;
    tick();
    n_total++;
    if ({i16_ready, busy16, o16_valid} !== 3'b100)
      $display("FAIL busy_after_consume: ready/busy/valid=%b%b%b want 100", i16_ready, busy16, o16_valid);
    else n_pass++;
  endtask

  task automatic test_backpressure();
    int lat, bad;
    o16_ready = 1'b0;
    drive16(16'h8000, 16'h8000, 1'b0);
    lat = 0;
    while (!o16_valid && lat < 20) begin tick(); lat++; end
    bad = 0;
    for (int i = 0; i < 6; i++) begin
      i16_valid = 1'b1; a16 = 16'($urandom); b16 = 16'($urandom); cin16 = 1'b1;
      if ({o16_valid, i16_ready, c16, s16} !== {1'b1, 1'b0, 1'b1, 16'h0000}) bad++;
      tick();
    end
    i16_valid = 1'b0;
    n_total++;
    if (bad !== 0 || {o16_valid, c16, s16} !== {1'b1, 1'b1, 16'h0000})
      $display("FAIL backpressure_hold: %0d unstable cycles, now valid/cout/sum=%b/%b/%h want 1/1/0000",
               bad, o16_valid, c16, s16);
    else n_pass++;
    o16_ready = 1'b1;
    tick();
    n_total++;
    if ({o16_valid, i16_ready} !== 2'b01)
      $display("FAIL backpressure_release: valid/ready=%b%b want 01", o16_valid, i16_ready);
    else n_pass++;
  endtask

  task automatic test_reset_mid_run();
    int lat, stray;
    o16_ready = 1'b1;
    drive16(16'h00FF, 16'h0001, 1'b0);
    tick();
    tick();
    rst_n = 1'b0;
    #1;
    n_total++;
    if ({i16_ready, o16_valid, busy16, c16, s16} !== {1'b1, 1'b0, 1'b0, 1'b0, 16'h0000})
      $display("FAIL midrun_reset: rdy/vld/busy/cout/sum=%b/%b/%b/%b/%h want 1/0/0/0/0000",
               i16_ready, o16_valid, busy16, c16, s16);
    else n_pass++;
    @(negedge clk);
    rst_n = 1'b1;
    tick();
    stray = 0;
    for (int i = 0; i < 6; i++) begin
      if (o16_valid || !i16_ready) stray++;
      tick();
    end
    n_total++;
    if (stray !== 0) $display("FAIL midrun_after_release: %0d cycles not idle, want 0", stray);
    else n_pass++;
    drive16(16'h0001, 16'h0001, 1'b0);
    lat = 0;
    while (!o16_valid && lat < 20) begin tick(); lat++; end
    n_total++;
    if ({c16, s16} !== 17'h0_0002 || lat !== 4)
      $display("FAIL midrun_next_op: got %b_%h lat %0d want 0_0002 lat 4", c16, s16, lat);
    else n_pass++;
    tick();
  endtask

  task automatic test_width4();
    int lat;
    o4_ready = 1'b1;
    i4_valid = 1'b1; a4 = 4'hF; b4 = 4'hF; cin4 = 1'b1;
    tick();
    i4_valid = 1'b0;
    lat = 0;
    while (!o4_valid && lat < 20) begin tick(); lat++; end
    n_total++;
    if ({c4, s4} !== 5'h1F || lat !== 1)
      $display("FAIL width4: got %b_%h lat %0d want 1_f lat 1", c4, s4, lat);
    else n_pass++;
    tick();
  endtask

  task automatic test_random16();
    logic [16:0] q[$];
    logic [16:0] exp;
    int sent, got, cyc, extra;
    sent = 0; got = 0; cyc = 0;
    while (got < 1000 && cyc < 40000) begin
      o16_ready = ($urandom_range(0, 3) != 0);
      if (o16_valid && o16_ready) begin
        n_total++;
        if (q.size() == 0) $display("FAIL rand16_extra: result %b_%h with empty scoreboard", c16, s16);
        else begin
          exp = q.pop_front();
          if ({c16, s16} !== exp) $display("FAIL rand16_result: got %h want %h", {c16, s16}, exp);
          else n_pass++;
        end
        got++;
      end
      if (sent < 1000 && $urandom_range(0, 3) != 0) begin
        i16_valid = 1'b1; a16 = 16'($urandom); b16 = 16'($urandom); cin16 = 1'($urandom);
        if (i16_ready) begin
          q.push_back(17'(a16) + 17'(b16) + 17'(cin16));
          sent++;
        end
      end else begin
        i16_valid = 1'b0;
      end
      tick(); cyc++;
    end
    i16_valid = 1'b0;
    o16_ready = 1'b1;
    extra = 0;
    for (int i = 0; i < 10; i++) begin tick(); if (o16_valid) extra++; end
    n_total++;
    if (got !== 1000 || q.size() !== 0 || extra !== 0)
      $display("FAIL rand16_count: got %0d results, %0d pending, %0d stray, want 1000/0/0", got, q.size(), extra);
    else n_pass++;
  endtask

  task automatic test_random32();
    logic [32:0] q[$];
    logic [32:0] exp;
    int sent, got, cyc, extra;
    sent = 0; got = 0; cyc = 0;
    while (got < 1000 && cyc < 40000) begin
      o32_ready = ($urandom_range(0, 3) != 0);
      if (o32_valid && o32_ready) begin
        n_total++;
        if (q.size() == 0) $display("FAIL rand32_extra: result %b_%h with empty scoreboard", c32, s32);
        else begin
          exp = q.pop_front();
          if ({c32, s32} !== exp) $display("FAIL rand32_result: got %h want %h", {c32, s32}, exp);
          else n_pass++;
        end
        got++;
      end
      if (sent < 1000 && $urandom_range(0, 3) != 0) begin
        i32_valid = 1'b1; a32 = $urandom; b32 = $urandom; cin32 = 1'($urandom);
        if (i32_ready) begin
          q.push_back(33'(a32) + 33'(b32) + 33'(cin32));
          sent++;
        end
      end else begin
        i32_valid = 1'b0;
      end
      tick(); cyc++;
    end
    i32_valid = 1'b0;
    o32_ready = 1'b1;
    extra = 0;
    for (int i = 0; i < 10; i++) begin tick(); if (o32_valid) extra++; end
    n_total++;
    if (got !== 1000 || q.size() !== 0 || extra !== 0)
      $display("FAIL rand32_count: got %0d results, %0d pending, %0d stray, want 1000/0/0", got, q.size(), extra);
    else n_pass++;
  endtask

  initial begin
    test_reset();
    test_carry_ripple();
    test_busy_ready();
    test_backpressure();
    test_reset_mid_run();
    test_width4();
    test_random16();
    test_random32();
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
